// File: rtl/daughter_power_sequencer_pkg.sv
// Shared types and constants for the daughterboard power sequencer.
// Rail bit positions, FSM encoding and delay counter width.
package daughter_power_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ON  = 2'd1,
      ST_WAIT_OFF = 2'd2
   } seq_state_e;

   localparam int NUM_RAILS = 4;
   localparam int RAIL_W    = $clog2(NUM_RAILS);
   localparam int PWR_LSB   = 0;
   localparam int DRV_LSB   = 4;
   localparam int CNT_W     = 16;

   // Per-rail mismatch; requested drive only counts when power is requested.
   function automatic logic [NUM_RAILS-1:0] rail_mismatch(
      input logic [NUM_RAILS-1:0] st_pwr,
      input logic [NUM_RAILS-1:0] st_drv,
      input logic [NUM_RAILS-1:0] tg_pwr,
      input logic [NUM_RAILS-1:0] tg_drv
   );
      return (st_pwr ^ tg_pwr) | (st_drv ^ (tg_drv & tg_pwr));
   endfunction

endpackage

// File: rtl/daughter_power_sequencer_rr_pick.sv
// Round-robin picker: first set bit of mismatch_i at or after ptr_i.
// Purely combinational.
module power_seq_rr_pick #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mismatch_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   logic [2*N-1:0] dbl;
   logic [IW:0]    sum;

   // Rotate so bit 0 is the pointer slot, then take the lowest set bit.
   always_comb begin
      dbl     = {mismatch_i, mismatch_i} >> ptr_i;
      idx_o   = '0;
      sum     = '0;
      valid_o = |mismatch_i;
      for (int k = N - 1; k >= 0; k--) begin
         if (dbl[k]) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
               sum = sum - (IW+1)'(N);
            end
            idx_o = sum[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/daughter_power_sequencer.sv
// Daughterboard power/drive sequencer: one rail pair per job,
// drive follows power by ON_DELAY, power follows drive-off by OFF_DELAY.
module daughter_power_sequencer
   import daughter_power_sequencer_pkg::*;
#(
   parameter  int NUM_DAUGHTERS = 4,
   parameter  int ON_DELAY      = 1000,
   parameter  int OFF_DELAY     = 100,
   localparam int IW = (NUM_DAUGHTERS > 1) ? $clog2(NUM_DAUGHTERS) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [8*NUM_DAUGHTERS-1:0] target_i,
   input  logic                       kill_i,
   output logic [8*NUM_DAUGHTERS-1:0] state_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [IW-1:0]              active_o
);

   localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_DELAY - 1);
   localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_DELAY - 1);

   seq_state_e                 fsm_q, fsm_d;
   logic [8*NUM_DAUGHTERS-1:0] state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]              rr_q, rr_d;
   logic [IW-1:0]              act_q, act_d;
   logic [RAIL_W-1:0]          j_q, j_d;
   logic                       td_q, td_d;
   logic                       done_q, done_d;

   logic [NUM_DAUGHTERS-1:0]   dmis;
   logic [IW-1:0]              pick_idx;
   logic                       pick_vld;

   logic [IW-1:0]              wk_idx, nxt_rr;
   logic [NUM_RAILS-1:0]       wk_pwr, wk_drv, tg_pwr, tg_drv;
   logic [NUM_RAILS-1:0]       mm, jm;
   logic [RAIL_W-1:0]          sel_j, jsel;
   logic                       tp, td, cp, cd, complete;

   // Which daughters have any rail pair out of step with its target.
   always_comb begin
      dmis = '0;
      for (int d = 0; d < NUM_DAUGHTERS; d++) begin
         dmis[d] = |rail_mismatch(state_q[8*d+PWR_LSB +: NUM_RAILS],
                                  state_q[8*d+DRV_LSB +: NUM_RAILS],
                                  target_i[8*d+PWR_LSB +: NUM_RAILS],
                                  target_i[8*d+DRV_LSB +: NUM_RAILS]);
      end
   end

   power_seq_rr_pick #(
      .N (NUM_DAUGHTERS)
   ) u_pick (
      .mismatch_i (dmis),
      .ptr_i      (rr_q),
      .idx_o      (pick_idx),
      .valid_o    (pick_vld)
   );

   // Job selection, start actions, delay countdown and kill override.
   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      act_d    = act_q;
      j_d      = j_q;
      td_d     = td_q;
      done_d   = 1'b0;
      complete = 1'b0;
      wk_pwr   = '0;
      wk_drv   = '0;
      tg_pwr   = '0;
      tg_drv   = '0;
      sel_j    = '0;

      wk_idx = (fsm_q == ST_IDLE) ? pick_idx : act_q;
      for (int d = 0; d < NUM_DAUGHTERS; d++) begin
         if (wk_idx == IW'(d)) begin
            wk_pwr = state_q[8*d+PWR_LSB +: NUM_RAILS];
            wk_drv = state_q[8*d+DRV_LSB +: NUM_RAILS];
            tg_pwr = target_i[8*d+PWR_LSB +: NUM_RAILS];
            tg_drv = target_i[8*d+DRV_LSB +: NUM_RAILS];
         end
      end
      nxt_rr = (wk_idx == IW'(NUM_DAUGHTERS - 1)) ? '0 : wk_idx + 1'b1;

      mm = rail_mismatch(wk_pwr, wk_drv, tg_pwr, tg_drv);
      for (int j = NUM_RAILS - 1; j >= 0; j--) begin
         if (mm[j]) sel_j = RAIL_W'(j);
      end
      jsel = (fsm_q == ST_IDLE) ? sel_j : j_q;
      jm   = NUM_RAILS'(1) << jsel;
      tp   = |(tg_pwr & jm);
      td   = |(tg_drv & jm) & tp;
      cp   = |(wk_pwr & jm);
      cd   = |(wk_drv & jm);

      case (fsm_q)
         ST_IDLE: begin
            if (pick_vld) begin
               act_d = pick_idx;
               j_d   = sel_j;
               td_d  = td;
               if (cd && !td) begin
                  wk_drv = wk_drv & ~jm;
                  if (tp) begin
                     complete = 1'b1;
                  end else begin
                     cnt_d = OFF_CNT;
                     fsm_d = ST_WAIT_OFF;
                  end
               end else if (!cp && tp) begin
                  wk_pwr = wk_pwr | jm;
                  cnt_d  = ON_CNT;
                  fsm_d  = ST_WAIT_ON;
               end else if (cp && tp) begin
                  wk_drv   = wk_drv | jm;
                  complete = 1'b1;
               end else begin
                  wk_pwr   = wk_pwr & ~jm;
                  complete = 1'b1;
               end
            end
         end
         ST_WAIT_ON: begin
            if (cnt_q == '0) begin
               if (td_q) wk_drv = wk_drv | jm;
               complete = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT_OFF: begin
            if (cnt_q == '0) begin
               wk_pwr   = wk_pwr & ~jm;
               complete = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase

      if (complete) begin
         fsm_d  = ST_IDLE;
         done_d = 1'b1;
         rr_d   = nxt_rr;
      end

      for (int d = 0; d < NUM_DAUGHTERS; d++) begin
         if (wk_idx == IW'(d)) begin
            state_d[8*d+PWR_LSB +: NUM_RAILS] = wk_pwr;
            state_d[8*d+DRV_LSB +: NUM_RAILS] = wk_drv;
         end
      end

      if (kill_i) begin
         state_d = '0;
         fsm_d   = ST_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
         rr_d    = rr_q;
         act_d   = act_q;
         j_d     = j_q;
         td_d    = td_q;
      end
   end

   // Sequencer state registers, cleared asynchronously on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         cnt_q   <= '0;
         rr_q    <= '0;
         act_q   <= '0;
         j_q     <= '0;
         td_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         act_q   <= act_d;
         j_q     <= j_d;
         td_q    <= td_d;
         done_q  <= done_d;
      end
   end

   assign state_o  = state_q;
   assign busy_o   = (fsm_q != ST_IDLE);
   assign done_o   = done_q;
   assign active_o = act_q;

endmodule

// File: tb/tb_daughter_power_sequencer.sv
// Scoreboard bench for the daughterboard power sequencer.
// Expected job completions are queued; a monitor checks each done_o.
module tb_daughter_power_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] target;
   logic        kill;
   logic [31:0] state_o;
   logic        busy_o;
   logic        done_o;
   logic [1:0]  active_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int c;

   typedef struct {
      logic [1:0]  act;
      logic [31:0] st;
      int          at;
   } exp_t;

   exp_t exp_q[$];

   daughter_power_sequencer #(
      .NUM_DAUGHTERS (4),
      .ON_DELAY      (4),
      .OFF_DELAY     (2)
   ) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .target_i (target),
      .kill_i   (kill),
      .state_o  (state_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .active_o (active_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [1:0] a, input logic [31:0] s,
                       input int at);
      exp_t e;
      e.act = a;
      e.st  = s;
      e.at  = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && done_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_done got=1 exp=0 st=%h cyc=%0d",
                     state_o, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_active", 32'(active_o), 32'(e.act));
            chk("sb_state", state_o, e.st);
            chk("sb_cycle", 32'(cyc), 32'(e.at));
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      kill   = 1'b0;
      target = '0;
      step(2);
      chk("rst_state", state_o, 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_done", 32'(done_o), 32'h0);
      chk("rst_active", 32'(active_o), 32'h0);
      rst_n = 1'b1;
      step(2);
      chk("idle_state", state_o, 32'h0);

      // Power-up of daughter 0 rail 0: drive ON_DELAY edges after power.
      c = cyc;
      target = 32'h11;
      push(2'd0, 32'h11, c + 5);
      step(1);
      chk("on_pwr", state_o, 32'h01);
      chk("on_busy", 32'(busy_o), 32'h1);
      step(3);
      chk("on_hold", state_o, 32'h01);
      step(2);
      chk("on_idle", 32'(busy_o), 32'h0);
      chk("on_done_low", 32'(done_o), 32'h0);

      // Power-down: power clears OFF_DELAY edges after drive.
      c = cyc;
      target = 32'h00;
      push(2'd0, 32'h00, c + 3);
      step(1);
      chk("off_drv", state_o, 32'h01);
      chk("off_busy", 32'(busy_o), 32'h1);
      step(1);
      chk("off_hold", state_o, 32'h01);
      step(2);
      chk("off_idle", 32'(busy_o), 32'h0);

      // Drive requested without power: nothing happens.
      target = 32'h10;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("nopwr_state", state_o, 32'h0);
         chk("nopwr_busy", 32'(busy_o), 32'h0);
      end

      // Kill during WAIT_ON, then full sequence after release.
      c = cyc;
      target = 32'h11;
      step(1);
      chk("kill_pre", state_o, 32'h01);
      step(1);
      kill = 1'b1;
      step(1);
      chk("kill_state", state_o, 32'h0);
      chk("kill_busy", 32'(busy_o), 32'h0);
      step(1);
      chk("kill_hold", state_o, 32'h0);
      kill = 1'b0;
      push(2'd0, 32'h11, c + 9);
      step(1);
      chk("kill_resume", state_o, 32'h01);
      step(5);

      // Reset in WAIT_OFF clears state without a clock edge.
      target = 32'h00;
      step(1);
      chk("rst_mid_pre", state_o, 32'h01);
      chk("rst_mid_busy", 32'(busy_o), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_state", state_o, 32'h0);
      chk("rst_async_busy", 32'(busy_o), 32'h0);
      step(1);
      target = 32'h1111;
      step(1);
      chk("rst_hold", state_o, 32'h0);
      rst_n = 1'b1;

      // Two daughters: daughter 0 first, daughter 1 after its done.
      c = cyc;
      push(2'd0, 32'h0011, c + 5);
      push(2'd1, 32'h1111, c + 10);
      step(6);
      chk("rr_d1_pwr", state_o, 32'h0111);
      chk("rr_d1_active", 32'(active_o), 32'h1);
      step(5);

      // Second rail on d0 with wait, then d1 drive-only clear.
      c = cyc;
      target = 32'h0133;
      push(2'd0, 32'h1133, c + 5);
      push(2'd1, 32'h0133, c + 6);
      step(7);

      // d1 power clear completes on the selection edge.
      c = cyc;
      target = 32'h0033;
      push(2'd1, 32'h0033, c + 1);
      step(2);

      // Drive clear then drive set on d0, back-to-back immediate jobs.
      c = cyc;
      target = 32'h0013;
      push(2'd0, 32'h0013, c + 1);
      push(2'd0, 32'h0033, c + 2);
      step(1);
      target = 32'h0033;
      step(3);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/daughter_power_sequencer.md
DAUGHTER_POWER_SEQUENCER -- requirements
Module: daughter_power_sequencer

Interface
REQ-001 Parameter NUM_DAUGHTERS, default 4: number of daughterboard slots.
REQ-002 Parameter ON_DELAY, default 1000: cycles from power-bit set to drive-bit set, legal range 1..65535.
REQ-003 Parameter OFF_DELAY, default 100: cycles from drive-bit clear to power-bit clear, legal range 1..65535.
REQ-004 Port clk_i, input, 1: single clock; all logic on posedge.
REQ-005 Port rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port target_i, input, 8*NUM_DAUGHTERS: requested byte per daughter d at [8d+7:8d]; bits 0-3 power (DDA, TDA, DRSV9, DRSV10), bits 4-7 drive, same order.
REQ-007 Port kill_i, input, 1: emergency off.
REQ-008 Port state_o, output, 8*NUM_DAUGHTERS: applied power/drive bits, same layout as target_i.
REQ-009 Port busy_o, output, 1: high whenever FSM is not IDLE.
REQ-010 Port done_o, output, 1: one-cycle pulse on job completion.
REQ-011 Port active_o, output, clog2(NUM_DAUGHTERS): daughter of current or last job.

Function
REQ-012 Effective target per pair (d,j): tp = target bit j, td = target bit j+4 AND tp; drive is never requested without power.
REQ-013 A pair is mismatched when (state power, state drive) differs from (tp, td).
REQ-014 FSM states: IDLE, WAIT_ON, WAIT_OFF; one job (one pair) in flight at a time.
REQ-015 Selection in IDLE: first daughter with any mismatch, round-robin starting at rr pointer; within it, lowest mismatched j.
REQ-016 tp, td latched at job start; target_i changes during a job are ignored until the next selection.
REQ-017 Start action on the same edge the job is selected, by case:
- cd=1, td=0, tp=0: clear drive, counter=OFF_DELAY-1, go WAIT_OFF.
- cd=1, td=0, tp=1: clear drive, job complete.
- cp=0, tp=1: set power, counter=ON_DELAY-1, go WAIT_ON.
- cp=1, tp=1, cd=0, td=1: set drive, job complete.
- cp=1, tp=0, cd=0: clear power, job complete.
REQ-018 WAIT_ON/WAIT_OFF: counter decrements each cycle; at counter==0, WAIT_ON sets drive if latched td=1, WAIT_OFF clears power; then job complete.
REQ-019 Result: drive set exactly ON_DELAY edges after power set; power cleared exactly OFF_DELAY edges after drive cleared.
REQ-020 Job complete: FSM to IDLE, done_o high for one cycle, rr pointer = (d+1) mod NUM_DAUGHTERS; next selection no earlier than the following edge.
REQ-021 A daughter needing several pairs is serviced one pair per job, interleaved round-robin with other daughters.
REQ-022 kill_i high: on the next edge all state_o bits clear, FSM to IDLE, counter to 0, done_o low; no job starts while kill_i is high.
REQ-023 After kill_i falls, normal selection resumes from the current rr pointer.
REQ-024 State bits change only through REQ-017/018/022.

Reset
REQ-025 rst_n_i low forces state_o=0, FSM IDLE, counter=0, rr pointer=0, busy_o=0, done_o=0, active_o=0, asynchronously.
REQ-026 Reset deassertion mid-job does not resume the job; selection starts afresh on the first edge after release.

Structure
REQ-027 Shared package holds FSM state encoding, power/drive bit-position constants, and the 16-bit counter width.
REQ-028 Round-robin mismatch picker is a sub-module, power_seq_rr_pick (mismatch vector plus pointer in, index and valid out, combinational).

Verification
REQ-029 ON_DELAY=4, OFF_DELAY=2: target_i[7:0]=0x11 from reset -> state bit0 set at edge T, bit4 at T+4, done_o at T+4, busy_o low after.
REQ-030 From state 0x11, target 0x00 -> bit4 clears at T, bit0 at T+2, single done_o pulse.
REQ-031 Target 0x11 on daughters 0 and 1 simultaneously -> daughter 0 powers first; daughter 1 power set no earlier than edge after daughter 0 done_o.
REQ-032 Target 0x10 (drive without power) -> state_o stays 0x00, busy_o never asserts.
REQ-033 kill_i pulsed during WAIT_ON -> state_o=0 on next edge; after release with target 0x11 held, full sequence repeats with ON_DELAY spacing.
REQ-034 rst_n_i asserted mid-WAIT_OFF -> state_o=0 immediately without a clock edge; after release, targets re-sequenced from daughter 0.
